// File: rtl/alu_execute_unit_if.sv
// Issue/writeback bundle between the register file, upstream issue logic and alu_execute_unit.
interface alu_execute_unit_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [2:0]            alu_op;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [ADDR_WIDTH-1:0] dest_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  reg_wr_en;
  logic                  zero_flag;
  logic                  carry_flag;
  logic                  busy;

  modport slave (
    input  issue_valid, alu_op, rs1_data, rs2_data, dest_addr,
    output issue_ready, wr_addr, wr_data, reg_wr_en, zero_flag, carry_flag, busy
  );

  modport master (
    output issue_valid, alu_op, rs1_data, rs2_data, dest_addr,
    input  issue_ready, wr_addr, wr_data, reg_wr_en, zero_flag, carry_flag, busy
  );
endinterface

// File: rtl/alu_execute_unit.sv
// Execute stage: single-cycle ALU ops straight to the register-file write port,
// MUL as an iterative shift-add that stalls issue until its result is written.
module alu_execute_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  alu_execute_unit_if.slave io_bus
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned SW = $clog2(DATA_WIDTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SLT = 3'b101, OP_SLL = 3'b110, OP_MUL = 3'b111
  } op_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_mcand, w_mcand_nxt;
  logic [DW-1:0] r_mplier, w_mplier_nxt;
  logic [PW-1:0] r_acc, w_acc_nxt;
  logic [SW-1:0] r_count, w_count_nxt;
  logic [AW-1:0] r_dest, w_dest_nxt;
  logic [AW-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [DW-1:0] r_wr_data, w_wr_data_nxt;
  logic          r_wr_en, w_wr_en_nxt;
  logic          r_zero, w_zero_nxt;
  logic          r_carry, w_carry_nxt;

  logic          w_accept;
  logic [DW-1:0] w_alu_res;
  logic          w_alu_carry;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic [PW-1:0] w_shl;
  logic          w_slt;
  logic [PW-1:0] w_acc_step;

  assign io_bus.issue_ready = (r_state == S_IDLE) && reset;
  assign w_accept           = io_bus.issue_valid && io_bus.issue_ready;

  assign io_bus.wr_addr    = r_wr_addr;
  assign io_bus.wr_data    = r_wr_data;
  assign io_bus.reg_wr_en  = r_wr_en;
  assign io_bus.zero_flag  = r_zero;
  assign io_bus.carry_flag = r_carry;
  assign io_bus.busy       = (r_state == S_MUL);

  // Single-cycle result and carry for the presented opcode.
  always_comb begin
    w_sum       = {1'b0, io_bus.rs1_data} + {1'b0, io_bus.rs2_data};
    w_diff      = {1'b0, io_bus.rs1_data} - {1'b0, io_bus.rs2_data};
    w_shl       = {{DW{1'b0}}, io_bus.rs1_data} << io_bus.rs2_data[SW-1:0];
    w_slt       = $signed(io_bus.rs1_data) < $signed(io_bus.rs2_data);
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    case (op_t'(io_bus.alu_op))
      OP_ADD: begin w_alu_res = w_sum[DW-1:0];  w_alu_carry = w_sum[DW];  end
      OP_SUB: begin w_alu_res = w_diff[DW-1:0]; w_alu_carry = w_diff[DW]; end
      OP_AND: w_alu_res = io_bus.rs1_data & io_bus.rs2_data;
      OP_OR:  w_alu_res = io_bus.rs1_data | io_bus.rs2_data;
      OP_XOR: w_alu_res = io_bus.rs1_data ^ io_bus.rs2_data;
      OP_SLT: w_alu_res = DW'(w_slt);
      OP_SLL: begin w_alu_res = w_shl[DW-1:0]; w_alu_carry = |w_shl[PW-1:DW]; end
      default: ;
    endcase
  end

  // The last iteration's add must be visible to the writeback in the same edge.
  assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Next-state and writeback decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_mcand_nxt   = r_mcand;
    w_mplier_nxt  = r_mplier;
    w_acc_nxt     = r_acc;
    w_count_nxt   = r_count;
    w_dest_nxt    = r_dest;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_wr_en_nxt   = 1'b0;
    w_zero_nxt    = r_zero;
    w_carry_nxt   = r_carry;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (op_t'(io_bus.alu_op) == OP_MUL) begin
            w_state_nxt  = S_MUL;
            w_mcand_nxt  = {{DW{1'b0}}, io_bus.rs1_data};
            w_mplier_nxt = io_bus.rs2_data;
            w_acc_nxt    = '0;
            w_count_nxt  = '0;
            w_dest_nxt   = io_bus.dest_addr;
          end else begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = io_bus.dest_addr;
            w_wr_data_nxt = w_alu_res;
            w_zero_nxt    = (w_alu_res == '0);
            w_carry_nxt   = w_alu_carry;
          end
        end
      end
      S_MUL: begin
        w_acc_nxt    = w_acc_step;
        w_mcand_nxt  = PW'(r_mcand << 1);
        w_mplier_nxt = r_mplier >> 1;
        w_count_nxt  = SW'(r_count + SW'(1));
        if (r_count == SW'(DW - 1)) begin
          w_state_nxt   = S_IDLE;
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_dest;
          w_wr_data_nxt = w_acc_step[DW-1:0];
          w_zero_nxt    = (w_acc_step[DW-1:0] == '0);
          w_carry_nxt   = |w_acc_step[PW-1:DW];
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_dest    <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mcand   <= w_mcand_nxt;
      r_mplier  <= w_mplier_nxt;
      r_acc     <= w_acc_nxt;
      r_count   <= w_count_nxt;
      r_dest    <= w_dest_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_zero    <= w_zero_nxt;
      r_carry   <= w_carry_nxt;
    end
  end

endmodule

// File: tb/tb_alu_execute_unit.sv
// Scoreboard bench for alu_execute_unit: directed ops push expected writebacks, a monitor pops them.
module tb_alu_execute_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   cyc;

  alu_execute_unit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

  alu_execute_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic       zero;
    logic       carry;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.reg_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(bus.wr_data), 32'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr",    32'(bus.wr_addr),    32'(e.addr));
        check("wr_data",    32'(bus.wr_data),    32'(e.data));
        check("zero_flag",  32'(bus.zero_flag),  32'(e.zero));
        check("carry_flag", 32'(bus.carry_flag), 32'(e.carry));
        check("wr_cycle",   32'(cyc),            32'(e.cyc));
      end
    end
  end

  // Drive one op, wait (bounded) for acceptance, then optionally queue its expected writeback.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] d, input logic [7:0] ed, input logic ec,
                       input bit expect_wr);
    int   n;
    exp_t e;
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.alu_op      = op;
    bus.rs1_data    = a;
    bus.rs2_data    = b;
    bus.dest_addr   = d;
    n = 0;
    while (bus.issue_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.issue_ready !== 1'b1) begin
      check("issue_timeout", 32'(bus.issue_ready), 32'd1);
      bus.issue_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (expect_wr) begin
      e.addr  = d;
      e.data  = ed;
      e.zero  = (ed == 8'h00);
      e.carry = ec;
      e.cyc   = cyc + ((op == 3'b111) ? 8 : 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.issue_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_addr"},   32'(bus.wr_addr),     32'd0);
    check({tag, "_wr_data"},   32'(bus.wr_data),     32'd0);
    check({tag, "_wr_en"},     32'(bus.reg_wr_en),   32'd0);
    check({tag, "_zero"},      32'(bus.zero_flag),   32'd0);
    check({tag, "_carry"},     32'(bus.carry_flag),  32'd0);
    check({tag, "_busy"},      32'(bus.busy),        32'd0);
    check({tag, "_ready"},     32'(bus.issue_ready), 32'd0);
  endtask

  // Hold reset low for three cycles, checking reset values, then release.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_reset_outputs(tag);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check({tag, "_ready_after_release"}, 32'(bus.issue_ready), 32'd1);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    cyc             = 0;
    bus.issue_valid = 1'b0;
    bus.alu_op      = 3'b000;
    bus.rs1_data    = 8'h00;
    bus.rs2_data    = 8'h00;
    bus.dest_addr   = 2'd0;
    reset           = 1'b1;
    #1 reset        = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    #1;
    check("por_ready_after_release", 32'(bus.issue_ready), 32'd1);

    // ADD then SUB back-to-back
    issue(3'b000, 8'hF0, 8'h20, 2'd1, 8'h10, 1'b1, 1'b1);
    issue(3'b001, 8'h05, 8'h05, 2'd2, 8'h00, 1'b0, 1'b1);
    idle_cycle();
    idle_cycle();

    pulse_reset("mid");

    // Logic ops, SLT, SLL and boundary carries
    issue(3'b101, 8'hFF, 8'h01, 2'd0, 8'h01, 1'b0, 1'b1);
    issue(3'b110, 8'h81, 8'h03, 2'd3, 8'h08, 1'b1, 1'b1);
    idle_cycle();
    @(negedge clk);
    check("hold_wr_data", 32'(bus.wr_data),    32'h08);
    check("hold_carry",   32'(bus.carry_flag), 32'd1);
    check("idle_no_wr",   32'(bus.reg_wr_en),  32'd0);
    issue(3'b010, 8'hF0, 8'h3C, 2'd1, 8'h30, 1'b0, 1'b1);
    issue(3'b011, 8'hF0, 8'h0F, 2'd2, 8'hFF, 1'b0, 1'b1);
    issue(3'b100, 8'hAA, 8'hAA, 2'd3, 8'h00, 1'b0, 1'b1);
    issue(3'b001, 8'h03, 8'h05, 2'd0, 8'hFE, 1'b1, 1'b1);
    issue(3'b000, 8'hFF, 8'h01, 2'd1, 8'h00, 1'b1, 1'b1);
    issue(3'b101, 8'h01, 8'hFF, 2'd2, 8'h00, 1'b0, 1'b1);
    issue(3'b110, 8'h11, 8'h00, 2'd3, 8'h11, 1'b0, 1'b1);
    idle_cycle();

    // MUL with busy/ready window
    issue(3'b111, 8'h0D, 8'h0B, 2'd3, 8'h8F, 1'b0, 1'b1);
    bus.issue_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mul_busy",     32'(bus.busy),        32'd1);
      check("mul_not_ready", 32'(bus.issue_ready), 32'd0);
    end
    @(negedge clk);
    check("mul_done_busy",  32'(bus.busy),        32'd0);
    check("mul_done_ready", 32'(bus.issue_ready), 32'd1);
    issue(3'b111, 8'h10, 8'h10, 2'd2, 8'h00, 1'b1, 1'b1);

    // ADD held valid during a MUL: accepted only once ready returns
    issue(3'b111, 8'h07, 8'h09, 2'd1, 8'h3F, 1'b0, 1'b1);
    issue(3'b000, 8'h01, 8'h02, 2'd0, 8'h03, 1'b0, 1'b1);
    idle_cycle();

    // Reset during MUL iteration 4: no writeback, next MUL correct
    issue(3'b111, 8'hFF, 8'hFF, 2'd1, 8'h00, 1'b0, 1'b0);
    bus.issue_valid = 1'b0;
    repeat (3) @(negedge clk);
    pulse_reset("mulabort");
    issue(3'b111, 8'h03, 8'h03, 2'd2, 8'h09, 1'b0, 1'b1);
    idle_cycle();

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_execute_unit.md
# alu_execute_unit

Execute stage directly downstream of the 4×8-bit register file read ports and upstream of its write port. It accepts an operation with two 8-bit operands and a 2-bit destination address through a valid/ready handshake. It computes the result and drives the register-file write port (`wr_addr`, `wr_data`, `reg_wr_en`) with a one-cycle write pulse. Single-cycle ALU ops are fully pipelined; MUL is an 8-iteration shift-add sequence that stalls issue.

## Interface
- `DATA_WIDTH`, default 8: operand and result width. Only 8 is supported.
- `ADDR_WIDTH`, default 2: register address width.
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. The block is in reset while `reset`=0.
- `issue_valid`  in  1  upstream presents an operation.
- `issue_ready`  out  1  block can accept. Combinational: 1 when state=IDLE and not in reset.
- `alu_op`  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 MUL.
- `rs1_data`  in  8  operand A, from register file `rs1_data`.
- `rs2_data`  in  8  operand B, from register file `rs2_data`.
- `dest_addr`  in  2  destination register.
- `wr_addr`  out  2  to register file `wr_addr`. Registered.
- `wr_data`  out  8  to register file `wr_data`. Registered.
- `reg_wr_en`  out  1  to register file `reg_wr_en`. Registered, 1-cycle pulse per result.
- `zero_flag`  out  1  1 when the last written result is 0x00.
- `carry_flag`  out  1  carry/borrow/overflow of the last result (see Operation).
- `busy`  out  1  1 while state=MUL.

## Operation
- **Accept** when `issue_valid`=1 and `issue_ready`=1 at a rising edge. In all other cycles `issue_valid` is ignored; upstream holds its values until accepted.
- **States:**
  - IDLE. Non-MUL accept stays in IDLE. MUL accept goes to MUL.
  - MUL. Stays for 8 iterations, then returns to IDLE.
- **Single-cycle ops**, result truncated to 8 bits:
  - ADD: `rs1+rs2`. Carry = bit 8 of the 9-bit sum.
  - SUB: `rs1−rs2`. Carry = borrow, i.e. 1 iff `rs1<rs2` (unsigned).
  - AND, OR, XOR: bitwise. Carry = 0.
  - SLT: signed two's-complement compare. Result 0x01 if `rs1<rs2`, else 0x00. Carry = 0.
  - SLL: `rs1 << rs2[2:0]`. Carry = OR of the bits shifted out.
- **MUL:**
  - On accept, latch the 16-bit multiplicand = `{8'h00, rs1}`, multiplier = `rs2`, acc = 0, count = 0, and the destination.
  - Each MUL cycle: if multiplier[0], acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
  - After the iteration with count=7: `wr_data` = acc[7:0] (including that iteration's add), carry = |acc[15:8], state → IDLE.
- **Writeback** on every result: `wr_addr` = latched destination, `wr_data` = result, `reg_wr_en`=1 for exactly one cycle. `zero_flag` and `carry_flag` update in the same edge.
- **Holding and pulse rules:**
  - `wr_addr`, `wr_data` and the flags hold their values until the next result.
  - `reg_wr_en`=0 in any cycle without a new result.
- **Destination:** `dest_addr`=0 is a normal write; there is no hardwired-zero register.
- **Back-to-back:** single-cycle ops issued on consecutive edges produce `reg_wr_en`=1 on consecutive cycles, each with its own address and data.
- **Reset:**
  - Async assertion forces state=IDLE and `wr_addr`=0, `wr_data`=0x00, `reg_wr_en`=0, `zero_flag`=0, `carry_flag`=0, `busy`=0, `issue_ready`=0.
  - Internal acc, count and operand registers are cleared.
  - A MUL in flight is aborted and produces no writeback.
  - After deassertion, `issue_ready`=1 immediately (combinational from IDLE).

## Timing
- **Non-MUL latency 1:** accepted at edge N, so `reg_wr_en`=1 with the result during the cycle after edge N. Throughput 1 op/cycle.
- **MUL latency 8:**
  - Accepted at edge N, iterations at edges N+1 … N+8.
  - The result is registered at edge N+8, so `reg_wr_en`=1 during the cycle after N+8.
  - `issue_ready`=0 and `busy`=1 from after edge N until edge N+8.
  - The earliest next accept is edge N+9.
- **No write-data forwarding:** a dependent op reads register-file data only after the write edge. Sequencing is upstream's job.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles mid-stream, then release. Expect all outputs at their reset values while low, and `issue_ready`=1 the cycle after release.
- **ADD then SUB back-to-back:**
  - ADD 0xF0+0x20 → r1 gives `wr_data`=0x10, carry=1, zero=0, `reg_wr_en`=1 one cycle after accept.
  - Next cycle, SUB 0x05−0x05 → r2 gives 0x00, zero=1, carry=0.
- **SLT and SLL:**
  - SLT 0xFF vs 0x01 → 0x01 (−1<1).
  - SLL 0x81 by 0x03 → 0x08, carry=1.
- **MUL:**
  - 0x0D×0x0B → r3: `busy`=1 and `issue_ready`=0 for 8 cycles, a single write of 0x8F, carry=0.
  - 0x10×0x10: write of 0x00, carry=1, zero=1.
- **Issue while busy:** hold `issue_valid`=1 with ADD during a MUL. Expect no accept until `issue_ready`=1, and the ADD result one cycle after that accept, following the MUL writeback.
- **Reset mid-MUL:** assert `reset` at iteration 4. Expect no `reg_wr_en` pulse, and the next MUL after release computes correctly (0x03×0x03 → 0x09).
